// File: rtl/m_sync_filt_arst.sv
// Multi-channel input synchronizer with a per-channel run-length glitch filter
// and registered rise/fall pulses. Each async input passes through a STAGES-deep
// sync chain. A change is accepted only once it has persisted for more than
// filt_len consecutive cycles.

// Single async-reset flop that forms the metastability-catching first stage.
module m_ffsync_arst (
    input  logic CK,
    input  logic RN,
    input  logic D,
    output logic Q
);
    // Capture the raw asynchronous input; clears to 0 on reset.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) Q <= 1'b0;
        else     Q <= D;
    end
endmodule

module m_sync_filt_arst #(
    parameter int               WIDTH   = 4,
    parameter int               STAGES  = 2,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic [CNT_W-1:0] filt_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("m_sync_filt_arst: STAGES must be in 2..4");
    end

    logic [WIDTH-1:0] s;

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        logic              first_s;
        logic [STAGES-2:0] tail;
        logic [CNT_W-1:0]  cnt;
        logic              q_r;
        logic              rise_r;
        logic              fall_r;

        // The first stage only resets to 0. Channels that must reset high
        // run it on inverted data, so the inverted output resets to 1.
        if (RST_VAL[ch]) begin : g_inv
            logic first_n;
            m_ffsync_arst u_ff (.CK(CK), .RN(RN), .D(~D[ch]), .Q(first_n));
            assign first_s = ~first_n;
        end else begin : g_dir
            m_ffsync_arst u_ff (.CK(CK), .RN(RN), .D(D[ch]), .Q(first_s));
        end

        // Remaining synchronizer stages, reset to the channel's rest level.
        always_ff @(posedge CK or negedge RN) begin
            if (!RN) begin
                tail <= {(STAGES-1){RST_VAL[ch]}};
            end else begin
                tail[0] <= first_s;
                for (int k = 1; k < STAGES - 1; k++) tail[k] <= tail[k-1];
            end
        end

        assign s[ch] = tail[STAGES-2];

        // Run-length filter. A break in the run clears the count. Using
        // ">=" lets a lowered filt_len commit on the next edge, and it keeps
        // cnt from running past filt_len.
        always_ff @(posedge CK or negedge RN) begin
            if (!RN) begin
                q_r    <= RST_VAL[ch];
                cnt    <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (s[ch] == q_r) begin
                    cnt <= '0;
                end else if (cnt >= filt_len) begin
                    q_r    <= s[ch];
                    cnt    <= '0;
                    rise_r <= s[ch];
                    fall_r <= ~s[ch];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign q[ch]    = q_r;
        assign rise[ch] = rise_r;
        assign fall[ch] = fall_r;
        assign busy[ch] = (cnt != '0);
    end
endmodule
